// File: rtl/mc_cpu_data_master.sv
// CPU-side initiator for the memory controller data port.
// Takes one load/store at a time, holds the strobe until ack or watchdog
// expiry, then presents a response until the pipeline consumes it.
module mc_cpu_data_master #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [15:0]       cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [15:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_data_o,
  input  logic              mem_ack_i,
  input  logic [15:0]       mem_data_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  // Watchdog fires when the counter reaches TIMEOUT-1 with no ack, so stb
  // has been high for exactly TIMEOUT cycles.
  localparam bit              LP_WD_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] LP_LAST = LP_WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_stb;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic                r_rsp_valid;
  logic [15:0]         r_rdata;
  logic                r_err;
  logic                w_expire;

  assign w_expire = LP_WD_EN && (r_cnt == LP_LAST);

  // Single-process FSM; every output is a register updated with the state.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cmd_valid_i) begin
            r_state     <= StReq;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_stb       <= 1'b1;
            r_we        <= cmd_we_i;
            r_addr      <= cmd_addr_i;
            r_wdata     <= cmd_wdata_i;
          end
        end
        StReq: begin
          if (mem_ack_i) begin
            // Ack wins over a coincident watchdog expiry.
            r_state     <= StResp;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rdata     <= r_we ? 16'h0000 : mem_data_i;
            r_err       <= 1'b0;
          end else if (w_expire) begin
            r_state     <= StResp;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rdata     <= 16'h0000;
            r_err       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_stb       <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign busy_o      = r_busy;
  assign mem_stb_o   = r_stb;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_data_o  = r_wdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_mc_cpu_data_master.sv
// Self-checking bench for mc_cpu_data_master: directed and random transactions
// on a TIMEOUT=8 instance, plus a TIMEOUT=4 instance for the ack/expiry race.
module tb_mc_cpu_data_master;

  localparam int TO  = 8;
  localparam int TO4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // Main instance (TIMEOUT=8)
  logic        cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, rsp_err;
  logic        mem_stb, mem_we, mem_ack, busy;
  logic [15:0] cmd_addr, cmd_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  // Second instance (TIMEOUT=4)
  logic        b_cmd_valid, b_cmd_ready, b_cmd_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic        b_mem_stb, b_mem_we, b_mem_ack, b_busy;
  logic [15:0] b_cmd_addr, b_cmd_wdata, b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] prev_rd;
  logic        prev_err;

  mc_cpu_data_master #(.ADDR_W(16), .TIMEOUT(TO), .CNT_W(8)) u_dut (
    .sys_clk     (clk),
    .sys_rst     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_stb_o   (mem_stb),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_data_i  (mem_rdata),
    .busy_o      (busy)
  );

  mc_cpu_data_master #(.ADDR_W(16), .TIMEOUT(TO4), .CNT_W(3)) u_dut_t4 (
    .sys_clk     (clk),
    .sys_rst     (rst_n),
    .cmd_valid_i (b_cmd_valid),
    .cmd_ready_o (b_cmd_ready),
    .cmd_we_i    (b_cmd_we),
    .cmd_addr_i  (b_cmd_addr),
    .cmd_wdata_i (b_cmd_wdata),
    .rsp_valid_o (b_rsp_valid),
    .rsp_ready_i (b_rsp_ready),
    .rsp_rdata_o (b_rsp_rdata),
    .rsp_err_o   (b_rsp_err),
    .mem_stb_o   (b_mem_stb),
    .mem_we_o    (b_mem_we),
    .mem_addr_o  (b_mem_addr),
    .mem_data_o  (b_mem_wdata),
    .mem_ack_i   (b_mem_ack),
    .mem_data_i  (b_mem_rdata),
    .busy_o      (b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full command on the main instance. ack_at is the 1-based stb cycle in
  // which ack is raised (0 = never); bp is the number of RESP cycles with
  // rsp_ready low. Expectations come from the behavioural rules only.
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int ack_at, input int bp, input logic [15:0] ack_data);
    int          n;
    int          exp_n;
    logic        ok;
    logic [15:0] exp_rd;
    ok     = (ack_at != 0) && (ack_at <= TO);
    exp_n  = ok ? ack_at : TO;
    exp_rd = (ok && !we) ? ack_data : 16'h0000;
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    mem_ack   = 1'b0;
    tick();
    n = 0;
    while (mem_stb && n < TO + 4) begin
      n++;
      check_eq("req_addr", 32'(mem_addr), 32'(addr));
      check_eq("req_we", 32'(mem_we), 32'(we));
      check_eq("req_wdata", 32'(mem_wdata), 32'(wdata));
      check_eq("req_ready", 32'(cmd_ready), 32'(0));
      check_eq("req_rsp_valid", 32'(rsp_valid), 32'(0));
      check_eq("req_busy", 32'(busy), 32'(1));
      check_eq("req_rdata_held", 32'(rsp_rdata), 32'(prev_rd));
      mem_ack   = (n == ack_at);
      mem_rdata = mem_ack ? ack_data : 16'($urandom);
      // Scrambled command inputs must not be taken while busy.
      cmd_valid = 1'($urandom);
      cmd_we    = 1'($urandom);
      cmd_addr  = 16'($urandom);
      cmd_wdata = 16'($urandom);
      tick();
    end
    mem_ack = 1'b0;
    check_eq("stb_cycles", 32'(n), 32'(exp_n));
    for (int i = 0; i <= bp; i++) begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'(1));
      check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      check_eq("rsp_err", 32'(rsp_err), 32'(!ok));
      check_eq("rsp_ready_low", 32'(cmd_ready), 32'(0));
      check_eq("rsp_stb", 32'(mem_stb), 32'(0));
      check_eq("rsp_addr_hold", 32'(mem_addr), 32'(addr));
      rsp_ready = (i == bp);
      // Late/spurious acks in RESP must be ignored.
      mem_ack   = 1'($urandom);
      mem_rdata = 16'($urandom);
      cmd_valid = (i == bp) ? 1'b0 : 1'($urandom);
      tick();
    end
    rsp_ready = 1'b0;
    mem_ack   = 1'b0;
    check_eq("done_valid", 32'(rsp_valid), 32'(0));
    check_eq("done_ready", 32'(cmd_ready), 32'(1));
    check_eq("done_busy", 32'(busy), 32'(0));
    check_eq("done_rdata_held", 32'(rsp_rdata), 32'(exp_rd));
    check_eq("done_err_held", 32'(rsp_err), 32'(!ok));
    check_eq("done_addr_held", 32'(mem_addr), 32'(addr));
    prev_rd  = exp_rd;
    prev_err = !ok;
  endtask

  // Load on the TIMEOUT=4 instance.
  task automatic run_b(input int ack_at, input logic [15:0] ack_data);
    int   n;
    logic ok;
    ok = (ack_at != 0) && (ack_at <= TO4);
    b_cmd_valid = 1'b1;
    b_cmd_we    = 1'b0;
    b_cmd_addr  = 16'h0010;
    tick();
    b_cmd_valid = 1'b0;
    n = 0;
    while (b_mem_stb && n < TO4 + 4) begin
      n++;
      b_mem_ack   = (n == ack_at);
      b_mem_rdata = b_mem_ack ? ack_data : 16'hDEAD;
      tick();
    end
    b_mem_ack = 1'b0;
    check_eq("t4_stb_cycles", 32'(n), 32'(ok ? ack_at : TO4));
    check_eq("t4_rsp_valid", 32'(b_rsp_valid), 32'(1));
    check_eq("t4_rsp_err", 32'(b_rsp_err), 32'(!ok));
    check_eq("t4_rsp_rdata", 32'(b_rsp_rdata), 32'(ok ? ack_data : 16'h0000));
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
    check_eq("t4_ready_again", 32'(b_cmd_ready), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    {cmd_valid, cmd_we, rsp_ready, mem_ack} = '0;
    {cmd_addr, cmd_wdata, mem_rdata} = '0;
    {b_cmd_valid, b_cmd_we, b_rsp_ready, b_mem_ack} = '0;
    {b_cmd_addr, b_cmd_wdata, b_mem_rdata} = '0;
    prev_rd  = 16'h0000;
    prev_err = 1'b0;
    #12;
    check_eq("rst_stb", 32'(mem_stb), 32'(0));
    check_eq("rst_we", 32'(mem_we), 32'(0));
    check_eq("rst_addr", 32'(mem_addr), 32'(0));
    check_eq("rst_wdata", 32'(mem_wdata), 32'(0));
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_eq("rst_rdata", 32'(rsp_rdata), 32'(0));
    check_eq("rst_err", 32'(rsp_err), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    rst_n = 1'b1;
    tick();

    // Spurious ack while idle.
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 1'b0;
    check_eq("idle_ack_busy", 32'(busy), 32'(0));
    check_eq("idle_ack_valid", 32'(rsp_valid), 32'(0));
    check_eq("idle_ack_rdata", 32'(rsp_rdata), 32'(0));

    // Directed cases.
    run_txn(1'b0, 16'h0123, 16'h0000, 3, 0, 16'hBEEF);  // load, ack after 3 stb cycles
    run_txn(1'b1, 16'h0040, 16'h5A5A, 1, 0, 16'h9999);  // store, ack first cycle
    run_txn(1'b0, 16'h0300, 16'h0000, 0, 4, 16'h0000);  // no ack: watchdog
    run_txn(1'b0, 16'h0301, 16'h0000, TO, 0, 16'h7777); // ack on last allowed cycle
    run_txn(1'b0, 16'h0777, 16'h0000, 2, 5, 16'hC0DE);  // backpressure

    // Randomized commands.
    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, TO + 2)),
              int'($urandom_range(0, 5)), 16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
        tick();
        mem_ack = 1'b0;
        check_eq("gap_ack_busy", 32'(busy), 32'(0));
        check_eq("gap_ack_rdata", 32'(rsp_rdata), 32'(prev_rd));
      end
    end

    // Asynchronous reset in the middle of a request.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 16'h0077;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_eq("pre_rst_stb", 32'(mem_stb), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_stb", 32'(mem_stb), 32'(0));
    check_eq("async_rst_valid", 32'(rsp_valid), 32'(0));
    check_eq("async_rst_busy", 32'(busy), 32'(0));
    tick();
    #2 rst_n = 1'b1;
    tick();
    check_eq("post_rst_valid", 32'(rsp_valid), 32'(0));
    prev_rd  = 16'h0000;
    prev_err = 1'b0;
    run_txn(1'b0, 16'h0002, 16'h0000, 2, 1, 16'h2222);

    // Ack coincident with expiry, then plain expiry, on the TIMEOUT=4 instance.
    run_b(4, 16'h1111);
    run_b(0, 16'h0000);
    run_b(2, 16'h3456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
